// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the MIPS-subset datapath.
// Traps into a sticky ERR state on illegal instructions or memory handshake timeouts.
module multicycle_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       beqout,
    input  logic       mem_rdy,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       MemRead,
    output logic       DMWrite,
    output logic       RegWrt,
    output logic [2:0] ALUctr,
    output logic [2:0] npc_sel,
    output logic [1:0] ExtOp,
    output logic [1:0] mux4_5sel,
    output logic [1:0] mux4_32sel,
    output logic       mux2sel,
    output logic       instr_done,
    output logic       err
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_ERR    = 3'd7;

    localparam int N_CLS = 9;

    localparam logic [3:0] C_ADD   = 4'd0;
    localparam logic [3:0] C_SUB   = 4'd1;
    localparam logic [3:0] C_ADDIU = 4'd2;
    localparam logic [3:0] C_LW    = 4'd3;
    localparam logic [3:0] C_SW    = 4'd4;
    localparam logic [3:0] C_BEQ   = 4'd5;
    localparam logic [3:0] C_LUI   = 4'd6;
    localparam logic [3:0] C_J     = 4'd7;
    localparam logic [3:0] C_JR    = 4'd8;

    // Decode table, one 6-bit slot per class, class 0 in the low slot.
    localparam logic [N_CLS*6-1:0] OP_TBL = {
        6'h00, 6'h02, 6'h0f, 6'h04, 6'h2b, 6'h23, 6'h09, 6'h00, 6'h00
    };
    localparam logic [N_CLS*6-1:0] FN_TBL = {
        6'h08, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h22, 6'h20
    };
    localparam logic [N_CLS-1:0] FN_USED = 9'b1_0000_0011;

    logic [2:0]       state_reg, state_next;
    logic [3:0]       class_reg, class_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    logic [N_CLS-1:0] dec_hit;
    logic [3:0]       dec_class;
    logic             dec_legal;
    logic             timeout_hit;

    logic [2:0] cls_alu;
    logic [1:0] cls_ext;
    logic [1:0] cls_m5;
    logic [1:0] cls_m32;
    logic       cls_m2;

    genvar gi;
    generate
        for (gi = 0; gi < N_CLS; gi++) begin : g_dec
            assign dec_hit[gi] = (op == OP_TBL[gi*6 +: 6]) &&
                                 (!FN_USED[gi] || (funct == FN_TBL[gi*6 +: 6]));
        end
    endgenerate

    always_comb begin
        dec_class = 4'd0;
        for (int i = 0; i < N_CLS; i++) begin
            if (dec_hit[i]) begin
                dec_class = 4'(i);
            end
        end
    end

    assign dec_legal   = |dec_hit;
    assign timeout_hit = (cnt_reg == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_next = state_reg;
        class_next = class_reg;
        case (state_reg)
            S_FETCH: begin
                if (mem_rdy) begin
                    state_next = S_DECODE;
                end else if (timeout_hit) begin
                    state_next = S_ERR;
                end
            end
            S_DECODE: begin
                if (dec_legal) begin
                    class_next = dec_class;
                    state_next = S_EXEC;
                end else begin
                    state_next = S_ERR;
                end
            end
            S_EXEC: begin
                if (class_reg == C_LW || class_reg == C_SW) begin
                    state_next = S_MEM;
                end else if (class_reg == C_BEQ || class_reg == C_J || class_reg == C_JR) begin
                    state_next = S_FETCH;
                end else begin
                    state_next = S_WB;
                end
            end
            S_MEM: begin
                if (mem_rdy) begin
                    state_next = (class_reg == C_LW) ? S_WB : S_FETCH;
                end else if (timeout_hit) begin
                    state_next = S_ERR;
                end
            end
            S_WB:    state_next = S_FETCH;
            S_ERR:   state_next = S_ERR;
            default: state_next = S_ERR;
        endcase
    end

    // The wait counter only runs while parked on the memory handshake.
    always_comb begin
        cnt_next = cnt_reg;
        if (state_next != state_reg) begin
            cnt_next = '0;
        end else if ((state_reg == S_FETCH || state_reg == S_MEM) && !mem_rdy) begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_FETCH;
            class_reg <= 4'd0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            class_reg <= class_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        cls_alu = 3'b000;
        cls_ext = 2'b00;
        cls_m5  = 2'b00;
        cls_m32 = 2'b10;
        cls_m2  = 1'b0;
        case (class_reg)
            C_ADD:   begin cls_alu = 3'b001; cls_m5 = 2'b01; cls_m32 = 2'b00; end
            C_SUB:   begin cls_alu = 3'b010; cls_m5 = 2'b01; cls_m32 = 2'b00; end
            C_ADDIU: begin cls_alu = 3'b001; cls_ext = 2'b10; cls_m32 = 2'b00; cls_m2 = 1'b1; end
            C_LW:    begin cls_alu = 3'b001; cls_ext = 2'b10; cls_m32 = 2'b01; cls_m2 = 1'b1; end
            C_SW:    begin cls_alu = 3'b001; cls_ext = 2'b10; cls_m2 = 1'b1; end
            C_BEQ:   begin cls_alu = 3'b010; cls_ext = 2'b10; end
            C_LUI:   begin cls_m32 = 2'b11; end
            default: begin end
        endcase
    end

    // Everything is forced low while rst is high so nothing leaks out of a reset cycle.
    always_comb begin
        PCWrite    = 1'b0;
        IRWrite    = 1'b0;
        MemRead    = 1'b0;
        DMWrite    = 1'b0;
        RegWrt     = 1'b0;
        ALUctr     = 3'b000;
        npc_sel    = 3'b000;
        ExtOp      = 2'b00;
        mux4_5sel  = 2'b00;
        mux4_32sel = 2'b00;
        mux2sel    = 1'b0;
        err        = 1'b0;
        if (!rst) begin
            if (state_reg == S_EXEC || state_reg == S_MEM || state_reg == S_WB) begin
                ALUctr     = cls_alu;
                ExtOp      = cls_ext;
                mux4_5sel  = cls_m5;
                mux4_32sel = cls_m32;
                mux2sel    = cls_m2;
            end
            case (state_reg)
                S_FETCH: begin
                    MemRead = 1'b1;
                    IRWrite = mem_rdy;
                end
                S_EXEC: begin
                    case (class_reg)
                        C_BEQ: begin PCWrite = 1'b1; npc_sel = beqout ? 3'b011 : 3'b000; end
                        C_J:   begin PCWrite = 1'b1; npc_sel = 3'b001; end
                        C_JR:  begin PCWrite = 1'b1; npc_sel = 3'b100; end
                        default: begin end
                    endcase
                end
                S_MEM: begin
                    if (class_reg == C_LW) begin
                        MemRead = 1'b1;
                    end else if (class_reg == C_SW) begin
                        DMWrite = 1'b1;
                        PCWrite = mem_rdy;
                    end
                end
                S_WB: begin
                    RegWrt  = 1'b1;
                    PCWrite = 1'b1;
                end
                S_ERR:   err = 1'b1;
                default: begin end
            endcase
        end
        instr_done = PCWrite;
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: each instruction is expanded into its
// expected per-cycle output schedule and compared cycle by cycle.
module tb_multicycle_ctrl;

    localparam int TIMEOUT = 16;

    localparam int K_ADD = 0, K_SUB = 1, K_ADDIU = 2, K_LW = 3, K_SW = 4;
    localparam int K_BEQ = 5, K_LUI = 6, K_J = 7, K_JR = 8, K_ILL = 9;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] op, funct;
    logic       beqout, mem_rdy;
    logic       PCWrite, IRWrite, MemRead, DMWrite, RegWrt;
    logic [2:0] ALUctr, npc_sel;
    logic [1:0] ExtOp, mux4_5sel, mux4_32sel;
    logic       mux2sel, instr_done, err;

    multicycle_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .beqout(beqout), .mem_rdy(mem_rdy),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .MemRead(MemRead), .DMWrite(DMWrite),
        .RegWrt(RegWrt), .ALUctr(ALUctr), .npc_sel(npc_sel), .ExtOp(ExtOp),
        .mux4_5sel(mux4_5sel), .mux4_32sel(mux4_32sel), .mux2sel(mux2sel),
        .instr_done(instr_done), .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc_count = 0;
    int txn = 0;
    bit ill_seen = 0;

    logic [19:0] got_vec;
    assign got_vec = {PCWrite, IRWrite, MemRead, DMWrite, RegWrt, ALUctr, npc_sel, ExtOp,
                      mux4_5sel, mux4_32sel, mux2sel, instr_done, err};

    function automatic logic [19:0] mk(input logic pcw, input logic irw, input logic mr,
                                       input logic dw, input logic rw, input logic [2:0] alu,
                                       input logic [2:0] npc, input logic [1:0] ext,
                                       input logic [1:0] m5, input logic [1:0] m32,
                                       input logic m2, input logic er);
        return {pcw, irw, mr, dw, rw, alu, npc, ext, m5, m32, m2, pcw, er};
    endfunction

    // Datapath selects each instruction needs, written straight from the ISA table.
    function automatic logic [19:0] fields(input int k);
        case (k)
            K_ADD:   return mk(0,0,0,0,0, 3'b001, 3'b000, 2'b00, 2'b01, 2'b00, 1'b0, 0);
            K_SUB:   return mk(0,0,0,0,0, 3'b010, 3'b000, 2'b00, 2'b01, 2'b00, 1'b0, 0);
            K_ADDIU: return mk(0,0,0,0,0, 3'b001, 3'b000, 2'b10, 2'b00, 2'b00, 1'b1, 0);
            K_LW:    return mk(0,0,0,0,0, 3'b001, 3'b000, 2'b10, 2'b00, 2'b01, 1'b1, 0);
            K_SW:    return mk(0,0,0,0,0, 3'b001, 3'b000, 2'b10, 2'b00, 2'b10, 1'b1, 0);
            K_BEQ:   return mk(0,0,0,0,0, 3'b010, 3'b000, 2'b10, 2'b00, 2'b10, 1'b0, 0);
            K_LUI:   return mk(0,0,0,0,0, 3'b000, 3'b000, 2'b00, 2'b00, 2'b11, 1'b0, 0);
            default: return mk(0,0,0,0,0, 3'b000, 3'b000, 2'b00, 2'b00, 2'b10, 1'b0, 0);
        endcase
    endfunction

    function automatic bit is_legal(input logic [5:0] o, input logic [5:0] f);
        if (o == 6'h00) return (f == 6'h20) || (f == 6'h22) || (f == 6'h08);
        return o inside {6'h09, 6'h23, 6'h2b, 6'h04, 6'h0f, 6'h02};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s txn=%0d got=%h exp=%h", tag, txn, got, exp);
        end
    endtask

    task automatic cyc(input logic rdy, input logic [19:0] exp, input string tag);
        mem_rdy = rdy;
        @(negedge clk);
        check(tag, {12'd0, got_vec}, {12'd0, exp});
        cyc_count++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mem_rdy = 1'b1;
        @(negedge clk);
        check("reset_cycle", {12'd0, got_vec}, 32'd0);
        @(posedge clk);
        #1;
        mem_rdy = $urandom_range(0, 1);
        @(negedge clk);
        check("reset_hold", {12'd0, got_vec}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic set_instr(input int k);
        op = 6'h00;
        funct = $urandom;
        case (k)
            K_ADD:   funct = 6'h20;
            K_SUB:   funct = 6'h22;
            K_JR:    funct = 6'h08;
            K_ADDIU: op = 6'h09;
            K_LW:    op = 6'h23;
            K_SW:    op = 6'h2b;
            K_BEQ:   op = 6'h04;
            K_LUI:   op = 6'h0f;
            K_J:     op = 6'h02;
            default: begin
                if (!ill_seen) begin
                    op = 6'h3f;
                    ill_seen = 1;
                end else begin
                    do begin
                        op = $urandom;
                        funct = $urandom;
                    end while (is_legal(op, funct));
                end
            end
        endcase
    endtask

    task automatic expect_err(input string tag);
        for (int i = 0; i < 3; i++) begin
            cyc($urandom_range(0, 1), mk(0,0,0,0,0, 3'b000, 3'b000, 2'b00, 2'b00, 2'b00, 1'b0, 1), tag);
        end
        do_reset();
    endtask

    task automatic log_txn(input int k, input int fs, input int ms, input int start, input string how);
        $display("txn %0d kind=%0d fetch_stall=%0d mem_stall=%0d cycles=%0d end=%s",
                 txn, k, fs, ms, cyc_count - start, how);
        txn++;
    endtask

    task automatic run_instr(input int k, input int fs, input int ms, input logic bq, input int rst_mem);
        logic [19:0] f, req, v_pcw, v_mr, v_irw, v_rw;
        logic [2:0]  npc;
        int start;
        start = cyc_count;
        f     = fields(k);
        v_pcw = mk(1,0,0,0,0, 3'b000, 3'b000, 2'b00, 2'b00, 2'b00, 1'b0, 0);
        v_irw = mk(0,1,0,0,0, 3'b000, 3'b000, 2'b00, 2'b00, 2'b00, 1'b0, 0);
        v_mr  = mk(0,0,1,0,0, 3'b000, 3'b000, 2'b00, 2'b00, 2'b00, 1'b0, 0);
        v_rw  = mk(0,0,0,0,1, 3'b000, 3'b000, 2'b00, 2'b00, 2'b00, 1'b0, 0);
        op = $urandom;
        funct = $urandom;
        beqout = $urandom_range(0, 1);
        for (int i = 0; i < fs && i < TIMEOUT; i++) cyc(1'b0, v_mr, "fetch_wait");
        if (fs >= TIMEOUT) begin
            expect_err("fetch_timeout");
            log_txn(k, fs, ms, start, "timeout");
            return;
        end
        cyc(1'b1, v_mr | v_irw, "fetch");
        set_instr(k);
        cyc($urandom_range(0, 1), 20'd0, "decode");
        if (k == K_ILL) begin
            expect_err("illegal");
            log_txn(k, fs, ms, start, "illegal");
            return;
        end
        beqout = bq;
        if (k == K_BEQ || k == K_J || k == K_JR) begin
            npc = (k == K_J) ? 3'b001 : (k == K_JR) ? 3'b100 : (bq ? 3'b011 : 3'b000);
            cyc($urandom_range(0, 1), f | v_pcw | mk(0,0,0,0,0, 3'b000, npc, 2'b00, 2'b00, 2'b00, 1'b0, 0), "exec_branch");
            log_txn(k, fs, ms, start, "done");
            return;
        end
        cyc($urandom_range(0, 1), f, "exec");
        beqout = ~bq;
        if (k == K_LW || k == K_SW) begin
            req = (k == K_LW) ? v_mr : mk(0,0,0,1,0, 3'b000, 3'b000, 2'b00, 2'b00, 2'b00, 1'b0, 0);
            for (int i = 0; i < ms && i < TIMEOUT; i++) begin
                if (i == rst_mem) begin
                    do_reset();
                    log_txn(k, fs, ms, start, "reset");
                    return;
                end
                cyc(1'b0, f | req, "mem_wait");
            end
            if (ms >= TIMEOUT) begin
                expect_err("mem_timeout");
                log_txn(k, fs, ms, start, "timeout");
                return;
            end
            if (k == K_SW) begin
                cyc(1'b1, f | req | v_pcw, "mem_sw");
                log_txn(k, fs, ms, start, "done");
                return;
            end
            cyc(1'b1, f | req, "mem_lw");
        end
        cyc($urandom_range(0, 1), f | v_rw | v_pcw, "wb");
        log_txn(k, fs, ms, start, "done");
    endtask

    initial begin
        int k, fs, ms, rm;
        rst = 1'b1;
        mem_rdy = 1'b0;
        op = 6'h00;
        funct = 6'h00;
        beqout = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        run_instr(K_ADD,   0,  0, 1'b0, -1);
        run_instr(K_LW,    0,  2, 1'b0, -1);
        run_instr(K_BEQ,   0,  0, 1'b1, -1);
        run_instr(K_BEQ,   0,  0, 1'b0, -1);
        run_instr(K_J,     0,  0, 1'b0, -1);
        run_instr(K_JR,    0,  0, 1'b1, -1);
        run_instr(K_ILL,   0,  0, 1'b0, -1);
        run_instr(K_ADD,  16,  0, 1'b0, -1);
        run_instr(K_SUB,  15,  0, 1'b0, -1);
        run_instr(K_SW,    0,  3, 1'b0,  1);
        run_instr(K_SW,    1, 15, 1'b0, -1);
        run_instr(K_LW,    0, 16, 1'b0, -1);
        run_instr(K_LUI,   2,  0, 1'b1, -1);
        run_instr(K_ADDIU, 0,  0, 1'b0, -1);

        for (int n = 0; n < 300; n++) begin
            k  = ($urandom_range(0, 19) == 0) ? K_ILL : int'($urandom_range(0, 8));
            fs = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 16)) : int'($urandom_range(0, 2));
            ms = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 16)) : int'($urandom_range(0, 3));
            rm = -1;
            if ((k == K_LW || k == K_SW) && ms > 0 && $urandom_range(0, 7) == 0)
                rm = int'($urandom_range(0, ms - 1));
            run_instr(k, fs, ms, 1'($urandom_range(0, 1)), rm);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
